// File: rtl/data_hazard_unit_pkg.sv
// rtl/data_hazard_unit_pkg.sv - shared opcodes, sizes and scoreboard types for the hazard unit
package data_hazard_unit_pkg;

    localparam int NREG = 4;
    localparam int RW   = 2;
    localparam int CNTW = 8;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STOP  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1010;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    localparam logic [2:0] OP_ORI_LO   = 3'b111;
    localparam logic [2:0] OP_SHIFT_LO = 3'b011;

    // ori has an implicit operand: it always reads and writes register 1
    localparam logic [RW-1:0] ORI_REG = RW'(1);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] dest;
    } sb_entry_t;

    typedef struct packed {
        logic          reads_a;
        logic          reads_b;
        logic [RW-1:0] src_a;
        logic [RW-1:0] src_b;
        logic          writes;
        logic [RW-1:0] dest;
    } decode_t;

    function automatic sb_entry_t to_entry(input decode_t d);
        sb_entry_t e;
        e.valid = d.writes;
        e.dest  = d.writes ? d.dest : '0;
        return e;
    endfunction

endpackage

// File: rtl/instr_reg_decode.sv
// rtl/instr_reg_decode.sv - combinational operand/destination decode of one instruction register
module instr_reg_decode
    import data_hazard_unit_pkg::*;
(
    input  logic [7:0] ir,
    output decode_t    dec
);

    logic [3:0]    op;
    logic [RW-1:0] ra;
    logic [RW-1:0] rb;

    assign op = ir[3:0];
    assign ra = ir[7:6];
    assign rb = ir[5:4];

    always_comb begin
        dec = '0;
        case (op)
            OP_LOAD: begin
                dec.reads_b = 1'b1;
                dec.src_b   = rb;
                dec.writes  = 1'b1;
                dec.dest    = ra;
            end
            OP_STORE: begin
                dec.reads_a = 1'b1;
                dec.src_a   = ra;
                dec.reads_b = 1'b1;
                dec.src_b   = rb;
            end
            OP_ADD, OP_SUB, OP_NAND: begin
                dec.reads_a = 1'b1;
                dec.src_a   = ra;
                dec.reads_b = 1'b1;
                dec.src_b   = rb;
                dec.writes  = 1'b1;
                dec.dest    = ra;
            end
            OP_BZ, OP_BNZ, OP_BPZ, OP_NOP, OP_STOP: begin
                dec = '0;
            end
            default: begin
                // ori/shift are identified by their low three bits only
                if (op[2:0] == OP_ORI_LO) begin
                    dec.reads_a = 1'b1;
                    dec.src_a   = ORI_REG;
                    dec.writes  = 1'b1;
                    dec.dest    = ORI_REG;
                end else if (op[2:0] == OP_SHIFT_LO) begin
                    dec.reads_a = 1'b1;
                    dec.src_a   = ra;
                    dec.writes  = 1'b1;
                    dec.dest    = ra;
                end
            end
        endcase
    end

endmodule

// File: rtl/data_hazard_unit.sv
// rtl/data_hazard_unit.sv - two-entry register scoreboard raising data_hazard for the decode stage
module data_hazard_unit #(
    parameter int NREG = data_hazard_unit_pkg::NREG,
    parameter int RW   = data_hazard_unit_pkg::RW,
    parameter int CNTW = data_hazard_unit_pkg::CNTW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [7:0]      IR1,
    input  logic            IR1Load,
    input  logic            IR2Sel,
    output logic            data_hazard,
    output logic [RW-1:0]   hazard_reg,
    output logic [NREG-1:0] pending,
    output logic [CNTW-1:0] hazard_count
);

    import data_hazard_unit_pkg::sb_entry_t;
    import data_hazard_unit_pkg::decode_t;
    import data_hazard_unit_pkg::to_entry;

    decode_t   dec;
    sb_entry_t e2;
    sb_entry_t e3;
    logic      prev_hazard;
    logic      match_a;
    logic      match_b;
    logic      hazard_rise;

    // IR1 holds are already covered by the bubble the FSM inserts into IR2
    logic unused_ir1load;
    assign unused_ir1load = IR1Load;

    instr_reg_decode u_decode (
        .ir  (IR1),
        .dec (dec)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            e2 <= '0;
            e3 <= '0;
        end else begin
            e3 <= e2;
            e2 <= IR2Sel ? to_entry(dec) : '0;
        end
    end

    // Writeback is not forwarded to a same-cycle read, so E3 is a hazard source too
    always_comb begin
        match_a = dec.reads_a &&
                  ((e2.valid && e2.dest == dec.src_a) || (e3.valid && e3.dest == dec.src_a));
        match_b = dec.reads_b &&
                  ((e2.valid && e2.dest == dec.src_b) || (e3.valid && e3.dest == dec.src_b));
        data_hazard = match_a || match_b;
        if (match_a) begin
            hazard_reg = dec.src_a;
        end else if (match_b) begin
            hazard_reg = dec.src_b;
        end else begin
            hazard_reg = '0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NREG; i++) begin
            pending[i] = (e2.valid && e2.dest == RW'(i)) || (e3.valid && e3.dest == RW'(i));
        end
    end

    assign hazard_rise = data_hazard && !prev_hazard;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_hazard  <= 1'b0;
            hazard_count <= '0;
        end else begin
            prev_hazard <= data_hazard;
            if (hazard_rise && hazard_count != {CNTW{1'b1}}) begin
                hazard_count <= hazard_count + 1'b1;
            end
        end
    end

endmodule
